// File: rtl/tele_receiver.sv
// tele_receiver: line-side monitor for the tele exchange. Decodes the ASCII
// status string, recovers talk-phase characters into a receive FIFO tagged
// with sender direction, and cross-checks the ASCII-hex bill at call end.
//
// state      | meaning
// IDLE       | no call on the line
// RINGING    | call offered, waiting for answer
// REJECTED   | call refused by callee
// CALLER     | talk phase, caller sending
// CALLEE     | talk phase, callee sending
// COST       | call over, bill presented on sentMsg
// UNKNOWN    | status string matched none of the above
module tele_receiver #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] statusMsg,
  input  logic [63:0] sentMsg,
  input  logic [31:0] cost,
  input  logic        rxReady,
  output logic        rxValid,
  output logic [7:0]  rxData,
  output logic        rxFromCallee,
  output logic [2:0]  lineState,
  output logic        callDone,
  output logic [31:0] billedCost,
  output logic [31:0] callCost,
  output logic        costMatch,
  output logic        hexErr,
  output logic        tariffErr,
  output logic        fifoOverflow,
  output logic        statusErr,
  output logic [15:0] callCount
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RINGING  = 3'd1,
    ST_REJECTED = 3'd2,
    ST_CALLER   = 3'd3,
    ST_CALLEE   = 3'd4,
    ST_COST     = 3'd5,
    ST_UNKNOWN  = 3'd7
  } line_t;

  line_t       state_q, state_d;
  logic [31:0] prev_cost;
  logic [31:0] start_cost;

  // state register: the decoded status delayed by one cycle doubles as prevState
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      prev_cost <= '0;
    end else begin
      state_q   <= state_d;
      prev_cost <= cost;
    end
  end

  // next state is simply the exact decode of the current status string
  always_comb begin
    state_d = ST_UNKNOWN;
    case (statusMsg)
      "IDLE    ": state_d = ST_IDLE;
      "RINGING ": state_d = ST_RINGING;
      "REJECTED": state_d = ST_REJECTED;
      "CALLER  ": state_d = ST_CALLER;
      "CALLEE  ": state_d = ST_CALLEE;
      "COST    ": state_d = ST_COST;
      default:    state_d = ST_UNKNOWN;
    endcase
  end

  assign lineState = state_q;

  // Direction comes from the previous state: a char 127 flips the exchange
  // state on the same edge that charges it.
  logic        talk, push, is_callee, is_digit, tariff_bad;
  logic [7:0]  ch;
  logic [31:0] delta, req_delta;
  logic        call_start, call_end;

  assign talk       = (state_q == ST_CALLER) || (state_q == ST_CALLEE);
  assign is_callee  = (state_q == ST_CALLEE);
  assign ch         = sentMsg[7:0];
  assign push       = talk && (cost != prev_cost);
  assign delta      = cost - prev_cost;
  assign is_digit   = (ch >= 8'd48) && (ch <= 8'd57);
  assign req_delta  = is_digit ? 32'd1 : 32'd2;
  assign tariff_bad = push && (delta != req_delta);
  assign call_start = (state_q == ST_IDLE) && (state_d == ST_RINGING);
  assign call_end   = (state_q == ST_COST) && (state_d == ST_IDLE);

  logic [31:0] bill_val;
  logic        bill_bad;
  logic [7:0]  bill_byte, bill_off;
  logic [3:0]  bill_nib;

  // ASCII-hex bill to binary; byte [63:56] is the most significant nibble
  always_comb begin
    bill_val  = '0;
    bill_bad  = 1'b0;
    bill_byte = '0;
    bill_off  = '0;
    bill_nib  = '0;
    for (int i = 0; i < 8; i++) begin
      bill_byte = sentMsg[i*8 +: 8];
      bill_off  = '0;
      bill_nib  = '0;
      if (bill_byte >= 8'd48 && bill_byte <= 8'd57) begin
        bill_off = bill_byte - 8'd48;
        bill_nib = bill_off[3:0];
      end else if (bill_byte >= 8'd65 && bill_byte <= 8'd70) begin
        bill_off = bill_byte - 8'd55;
        bill_nib = bill_off[3:0];
      end else begin
        bill_bad = 1'b1;
      end
      bill_val[i*4 +: 4] = bill_nib;
    end
  end

  // call bookkeeping: start latch, sticky flags and registered bill results
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_cost <= '0;
      callDone   <= 1'b0;
      billedCost <= '0;
      callCost   <= '0;
      costMatch  <= 1'b0;
      hexErr     <= 1'b0;
      tariffErr  <= 1'b0;
      statusErr  <= 1'b0;
      callCount  <= '0;
    end else begin
      callDone <= call_end;
      if (call_start) begin
        start_cost <= cost;
        tariffErr  <= 1'b0;
        hexErr     <= 1'b0;
      end
      if (tariff_bad)
        tariffErr <= 1'b1;
      if (call_end) begin
        billedCost <= bill_val;
        callCost   <= cost - start_cost;
        costMatch  <= (bill_val == cost);
        hexErr     <= bill_bad;
        callCount  <= callCount + 16'd1;
      end
      if (state_d == ST_UNKNOWN)
        statusErr <= 1'b1;
    end
  end

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, wr_en, drop;

  assign full    = (count == DEPTH_C);
  assign rxValid = (count != '0);
  assign pop     = rxValid && rxReady;
  assign wr_en   = push && (!full || pop);
  assign drop    = push && full && !pop;

  assign rxData       = rxValid ? mem[rd_ptr][7:0] : 8'd0;
  assign rxFromCallee = rxValid ? mem[rd_ptr][8]   : 1'b0;

  // receive FIFO; a full FIFO still accepts a push when the head pops that cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= {is_callee, ch};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // overflow flag lives for one call and is cleared when the next call rings
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      fifoOverflow <= 1'b0;
    else if (call_start)
      fifoOverflow <= 1'b0;
    else if (drop)
      fifoOverflow <= 1'b1;
  end

endmodule

// File: tb/tb_tele_receiver.sv
// Bench for tele_receiver: acts as the exchange, drives calls and characters,
// and scoreboards FIFO output and end-of-call bill results.
module tb_tele_receiver;

  localparam int DEPTH = 16;
  localparam logic [63:0] S_IDLE    = "IDLE    ";
  localparam logic [63:0] S_RINGING = "RINGING ";
  localparam logic [63:0] S_CALLER  = "CALLER  ";
  localparam logic [63:0] S_CALLEE  = "CALLEE  ";
  localparam logic [63:0] S_COST    = "COST    ";
  localparam logic [63:0] S_BOGUS   = "HELLO!!!";

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] statusMsg, sentMsg;
  logic [31:0] cost;
  logic        rxReady, rxValid, rxFromCallee, callDone, costMatch, hexErr;
  logic        tariffErr, fifoOverflow, statusErr;
  logic [7:0]  rxData;
  logic [2:0]  lineState;
  logic [31:0] billedCost, callCost;
  logic [15:0] callCount;

  tele_receiver #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .statusMsg(statusMsg), .sentMsg(sentMsg), .cost(cost),
    .rxReady(rxReady), .rxValid(rxValid), .rxData(rxData), .rxFromCallee(rxFromCallee),
    .lineState(lineState), .callDone(callDone), .billedCost(billedCost),
    .callCost(callCost), .costMatch(costMatch), .hexErr(hexErr), .tariffErr(tariffErr),
    .fifoOverflow(fifoOverflow), .statusErr(statusErr), .callCount(callCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] billed;
    logic [31:0] ccost;
    logic        match;
    logic        hex;
  } done_t;

  int          n_chk = 0;
  int          n_err = 0;
  logic [8:0]  sb[$];
  done_t       dq[$];
  logic [31:0] cost_r, start_cost;
  logic        cur_dir, exp_tariff, exp_ovf;
  int          exp_calls;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] hex8(input logic [31:0] v);
    logic [63:0] s;
    logic [3:0]  nib;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      nib = v[i*4 +: 4];
      s[i*8 +: 8] = (nib < 4'd10) ? (8'd48 + {4'd0, nib}) : (8'd55 + {4'd0, nib});
    end
    return s;
  endfunction

  // FIFO scoreboard: compare head whenever it is about to be popped
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst && rxValid && rxReady) begin
      if (sb.size() == 0) chk("rx_extra", 1, 0);
      else begin
        e = sb.pop_front();
        chk("rx_char", {rxFromCallee, rxData}, e);
      end
    end
  end

  // bill scoreboard: every callDone cycle must match one expected call end
  always @(negedge clk) begin
    done_t d;
    if (rst && callDone) begin
      if (dq.size() == 0) chk("spurious_done", 1, 0);
      else begin
        d = dq.pop_front();
        chk("billed_cost", billedCost, d.billed);
        chk("call_cost", callCost, d.ccost);
        chk("cost_match", costMatch, d.match);
        chk("hex_err", hexErr, d.hex);
      end
    end
  end

  task automatic start_call();
    statusMsg  = S_RINGING;
    start_cost = cost_r;
    tick(1);
    statusMsg  = S_CALLER;
    cur_dir    = 1'b0;
    exp_tariff = 1'b0;
    exp_ovf    = 1'b0;
    tick(1);
  endtask

  task automatic send_char(input logic [7:0] c, input logic [31:0] d);
    logic [31:0] req;
    if (sb.size() < DEPTH || rxReady) sb.push_back({cur_dir, c});
    else exp_ovf = 1'b1;
    req = (c >= 8'd48 && c <= 8'd57) ? 32'd1 : 32'd2;
    if (d != req) exp_tariff = 1'b1;
    cost_r = cost_r + d;
    cost   = cost_r;
    sentMsg[7:0] = c;
    if (c == 8'd127) begin
      statusMsg = cur_dir ? S_CALLER : S_CALLEE;
      cur_dir   = ~cur_dir;
    end
    tick(1);
  endtask

  task automatic end_call(input logic [63:0] bill, input logic [31:0] exp_billed, input logic exp_hex);
    done_t d;
    sentMsg   = bill;
    statusMsg = S_COST;
    tick(1);
    statusMsg = S_IDLE;
    d.billed  = exp_billed;
    d.ccost   = cost_r - start_cost;
    d.match   = (exp_billed == cost_r);
    d.hex     = exp_hex;
    dq.push_back(d);
    exp_calls++;
    tick(3);
    chk("done_seen", dq.size(), 0);
    chk("call_count", callCount, exp_calls);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    logic [63:0] b;
    rst = 1'b0; statusMsg = S_IDLE; sentMsg = '0; cost = '0; rxReady = 1'b0;
    cost_r = '0; start_cost = '0; cur_dir = 1'b0; exp_tariff = 1'b0; exp_ovf = 1'b0;
    exp_calls = 0;
    tick(3);
    rst = 1'b1;
    tick(10);
    chk("rst_line_state", lineState, 0);
    chk("rst_rx_valid", rxValid, 0);
    chk("rst_rx_data", {rxFromCallee, rxData}, 0);
    chk("rst_done", callDone, 0);
    chk("rst_bill", {billedCost, callCost}, 0);
    chk("rst_flags", {costMatch, hexErr, tariffErr, fifoOverflow, statusErr}, 0);
    chk("rst_count", callCount, 0);

    // basic call with direction switch on char 127
    rxReady = 1'b1;
    start_call();
    send_char(8'd53, 1);
    send_char(8'd65, 2);
    send_char(8'd127, 2);
    send_char(8'd122, 2);
    tick(2);
    wait_drain();
    chk("c1_tariff", tariffErr, exp_tariff);
    chk("c1_ovf", fifoOverflow, 0);
    end_call(hex8(cost_r), cost_r, 1'b0);

    // overflow: 17 chars with consumer stalled
    rxReady = 1'b0;
    start_call();
    for (int i = 0; i < 17; i++) send_char(8'(97 + i), 2);
    tick(1);
    chk("ovf_set", fifoOverflow, exp_ovf);
    chk("ovf_valid", rxValid, 1);
    end_call(hex8(cost_r), cost_r, 1'b0);
    start_call();
    chk("ovf_cleared", fifoOverflow, 0);
    chk("ovf_kept", rxValid, 1);
    rxReady = 1'b1;
    wait_drain();

    // tariff mismatch on a digit charged as 2
    send_char(8'd51, 2);
    send_char(8'd52, 1);
    tick(2);
    wait_drain();
    chk("tariff_err", tariffErr, exp_tariff);

    // bill with a non-hex byte in the low nibble
    b = hex8(cost_r);
    b[7:0] = 8'd71;
    end_call(b, {cost_r[31:4], 4'h0}, 1'b1);

    // unknown status string
    statusMsg = S_BOGUS;
    tick(1);
    chk("unk_state", lineState, 7);
    chk("unk_err", statusErr, 1);
    statusMsg = S_IDLE;
    tick(3);
    chk("unk_sticky", statusErr, 1);
    chk("unk_back_idle", lineState, 0);

    // reset in the middle of a call, then a clean call
    start_call();
    send_char(8'd55, 1);
    rst = 1'b0;
    sb.delete();
    dq.delete();
    statusMsg = S_IDLE;
    tick(2);
    chk("mid_rst_status_err", statusErr, 0);
    chk("mid_rst_count", callCount, 0);
    chk("mid_rst_valid", rxValid, 0);
    rst = 1'b1;
    exp_calls = 0;
    tick(2);
    start_call();
    send_char(8'd49, 1);
    send_char(8'd66, 2);
    tick(2);
    wait_drain();
    end_call(hex8(cost_r), cost_r, 1'b0);
    tick(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
